rtc_bus_scheduler: RTL and testbench
====================================

Name: rtc_bus_scheduler

Overview:
Sequences and arbitrates the single RTC parallel bus between the read FSM (do_it_lec/fin_lec) and the write FSM (do_it_esc/fin_esc).
- Issues a periodic read tick so time/date registers refresh automatically.
- Grants user write requests, holding each grant until the owning FSM reports completion.
- Drives the bus-owner select for the a_d/cs/rd/wr/direction multiplexer.

Parameters:
READ_PERIOD, 100, clock cycles between periodic read requests (>=2)
GAP_CYCLES, 4, idle guard cycles between consecutive bus transactions (0 allowed)
TIMEOUT, 1024, max cycles a transaction may run before abort (watchdog feature only)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  scheduler enable; low = no new transactions and read tick counter frozen
req_esc  in  1  write request level; held until ack_esc
fin_esc  in  1  write FSM done pulse
fin_lec  in  1  read FSM done pulse
do_it_esc  out  1  write FSM start/hold level
do_it_lec  out  1  read FSM start/hold level
ack_esc  out  1  one-cycle pulse, write transaction complete
dato_listo  out  1  one-cycle pulse, read transaction complete
sel_esc  out  1  bus owner select: 1 = write FSM, 0 = read FSM
busy  out  1  high in any state other than IDLE
err_timeout  out  1  sticky watchdog flag; constant 0 without the feature

Behaviour:
- All outputs are registered.
- Reset value is 0 for every output, the tick counter, read_pend, last_was_esc and the gap counter; state = IDLE.
- Read tick: while enable=1, the counter runs 0..READ_PERIOD-1. At wrap, read_pend is set.
  - A tick that arrives while read_pend is already set merges into it; there is no queue.
  - read_pend clears on entry to LEC.
- States: IDLE, LEC, ESC, GAP.
- IDLE, taken only when enable=1:
  - req_esc=1 and NOT (last_was_esc and read_pend) -> ESC.
  - Otherwise, read_pend=1 -> LEC.
  - This is write priority, except that a pending read is always served between two writes.
- Entering ESC: do_it_esc=1, sel_esc=1, last_was_esc=1, all on the same edge.
- Entering LEC: do_it_lec=1, sel_esc=0, last_was_esc=0.
- In ESC/LEC, do_it_* is held high regardless of enable or req_esc until the matching fin_* is sampled.
  - The fin sampled in ESC is fin_esc; in LEC it is fin_lec.
  - Sampling starts the first cycle of the state.
  - A non-matching fin is ignored.
- On the edge after fin is sampled:
  - do_it_* returns to 0.
  - ack_esc or dato_listo pulses for exactly one cycle.
  - State goes to GAP, or to IDLE if GAP_CYCLES=0.
- Latency: request visible in IDLE at edge N -> do_it_* high after edge N+1.
- GAP: counts GAP_CYCLES cycles, then IDLE. sel_esc holds its value through GAP and IDLE and changes only at transaction start.
- If req_esc drops before the grant, the request is withdrawn. If it drops after the grant, the write runs to completion.
- enable dropping mid-transaction: the transaction completes and the gap is served; the block then stays in IDLE.
- Asynchronous reset mid-transaction: immediate return to reset values, do_it_* forced to 0.

Optional Feature:
RTC_SCHED_WDOG_EN
- Defined: a cycle counter runs in LEC/ESC. If TIMEOUT cycles elapse without fin:
  - do_it_* is forced to 0.
  - No ack_esc/dato_listo pulse is issued.
  - err_timeout is set (sticky until reset).
  - State goes to GAP.
- Not defined: no counter; a missing fin holds the state indefinitely; err_timeout is tied to 0.

Decomposition:
- Package rtc_sched_pkg holds:
  - state encoding constants (IDLE=2'd0, LEC=2'd1, ESC=2'd2, GAP=2'd3);
  - the counter-width helper function (clog2);
  - default READ_PERIOD/GAP_CYCLES/TIMEOUT constants.
- Sub-module rtc_tick_gen: parameterised free-running period counter with enable input and a one-cycle tick output.

Test Plan:
Bench parameters for all scenarios: READ_PERIOD=100, GAP_CYCLES=4, TIMEOUT=64.
1. Release reset, enable=1, no req_esc, fin_lec returned 10 cycles after do_it_lec -> do_it_lec rises about every 100 cycles, dato_listo pulses once each, sel_esc stays 0.
2. req_esc=1 while idle, fin_esc after 20 cycles -> do_it_esc high 1 cycle after request, ack_esc pulse 1 cycle after fin_esc, busy low 4 cycles later.
3. req_esc held continuously with a read tick during the write -> next transaction is LEC, then ESC; reads and writes alternate.
4. Drop req_esc 5 cycles into a write (fin_esc at cycle 20) -> do_it_esc stays high until fin_esc, ack_esc still pulses.
5. Assert reset while in ESC -> all outputs 0 immediately; after release the first read occurs 100 cycles later.
6. With RTC_SCHED_WDOG_EN, never return fin_lec -> do_it_lec drops after 64 cycles, err_timeout=1, no dato_listo; the next read proceeds normally.

Source files
------------

// File: rtl/rtc_sched_pkg.sv
// rtc_sched_pkg: state encoding, default parameters and the counter-width helper for the RTC bus scheduler.
package rtc_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LEC  = 2'd1,
      ESC  = 2'd2,
      GAP  = 2'd3
   } state_t;

   localparam int unsigned DEF_READ_PERIOD = 100;
   localparam int unsigned DEF_GAP_CYCLES  = 4;
   localparam int unsigned DEF_TIMEOUT     = 1024;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r = r + 1;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/rtc_tick_gen.sv
// rtc_tick_gen: free-running 0..PERIOD-1 counter, frozen while en=0; tick is high for the last count.
module rtc_tick_gen
   import rtc_sched_pkg::*;
#(
   parameter int unsigned PERIOD = DEF_READ_PERIOD
)(
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int unsigned W = clog2(PERIOD);
   localparam logic [W-1:0] LAST = W'(PERIOD - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge reset)
      if (reset) cnt <= '0;
      else if (en) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/rtc_bus_scheduler.sv
// rtc_bus_scheduler: arbitrates the RTC parallel bus between the read and write FSMs with periodic reads.
// Optional transaction watchdog enabled by defining RTC_SCHED_WDOG_EN.
module rtc_bus_scheduler
   import rtc_sched_pkg::*;
#(
   parameter int unsigned READ_PERIOD = DEF_READ_PERIOD,
   parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
   parameter int unsigned TIMEOUT     = DEF_TIMEOUT
)(
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic req_esc,
   input  logic fin_esc,
   input  logic fin_lec,
   output logic do_it_esc,
   output logic do_it_lec,
   output logic ack_esc,
   output logic dato_listo,
   output logic sel_esc,
   output logic busy,
   output logic err_timeout
);

   localparam int unsigned GW = clog2(GAP_CYCLES + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
   localparam state_t POST = (GAP_CYCLES == 0) ? IDLE : GAP;

   state_t state, state_n;
   logic [GW-1:0] gap_cnt, gap_cnt_n;
   logic read_pend, read_pend_n, last_was_esc, last_n, tick;
   logic do_esc_n, do_lec_n, ack_n, dl_n, sel_n, fin, abort;

   rtc_tick_gen #(.PERIOD(READ_PERIOD)) u_tick (
      .clk   (clk),
      .reset (reset),
      .en    (enable),
      .tick  (tick)
   );

   assign fin = (state == ESC) ? fin_esc : fin_lec;

`ifdef RTC_SCHED_WDOG_EN
   localparam int unsigned TW = clog2(TIMEOUT);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
   logic [TW-1:0] wd_cnt;
   logic err_q;
   // A fin in the last allowed cycle still completes normally.
   assign abort = (state == ESC || state == LEC) && !fin && (wd_cnt == TO_LAST);
   assign err_timeout = err_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wd_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         wd_cnt <= (state == ESC || state == LEC) ? wd_cnt + 1'b1 : '0;
         err_q  <= err_q | abort;
      end
`else
   assign abort = 1'b0;
   assign err_timeout = 1'b0;
`endif

   always_comb begin
      state_n     = state;
      gap_cnt_n   = gap_cnt;
      read_pend_n = read_pend | tick;
      last_n      = last_was_esc;
      do_esc_n    = do_it_esc;
      do_lec_n    = do_it_lec;
      sel_n       = sel_esc;
      ack_n       = 1'b0;
      dl_n        = 1'b0;
      case (state)
         IDLE:
            if (enable) begin
               // Writes win, but a pending read always slips in between two writes.
               if (req_esc && !(last_was_esc && read_pend)) begin
                  state_n  = ESC;
                  do_esc_n = 1'b1;
                  sel_n    = 1'b1;
                  last_n   = 1'b1;
               end else if (read_pend) begin
                  state_n     = LEC;
                  do_lec_n    = 1'b1;
                  sel_n       = 1'b0;
                  last_n      = 1'b0;
                  read_pend_n = tick;
               end
            end
         ESC, LEC:
            if (fin || abort) begin
               state_n   = POST;
               gap_cnt_n = '0;
               do_esc_n  = 1'b0;
               do_lec_n  = 1'b0;
               ack_n     = fin && (state == ESC);
               dl_n      = fin && (state == LEC);
            end
         GAP: begin
            state_n   = (gap_cnt == GAP_LAST) ? IDLE : GAP;
            gap_cnt_n = gap_cnt + 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state        <= IDLE;
         gap_cnt      <= '0;
         read_pend    <= 1'b0;
         last_was_esc <= 1'b0;
         do_it_esc    <= 1'b0;
         do_it_lec    <= 1'b0;
         ack_esc      <= 1'b0;
         dato_listo   <= 1'b0;
         sel_esc      <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_n;
         gap_cnt      <= gap_cnt_n;
         read_pend    <= read_pend_n;
         last_was_esc <= last_n;
         do_it_esc    <= do_esc_n;
         do_it_lec    <= do_lec_n;
         ack_esc      <= ack_n;
         dato_listo   <= dl_n;
         sel_esc      <= sel_n;
         busy         <= (state_n != IDLE);
      end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// tb_rtc_bus_scheduler: directed cycle-exact checks of the RTC bus scheduler (READ_PERIOD=100, GAP=4, TIMEOUT=64).
module tb_rtc_bus_scheduler;

   logic clk = 1'b0, reset = 1'b1, enable = 1'b0;
   logic req_esc = 1'b0, fin_esc = 1'b0, fin_lec = 1'b0;
   logic do_it_esc, do_it_lec, ack_esc, dato_listo, sel_esc, busy, err_timeout;
   int tests = 0, fails = 0, now = 0;

   rtc_bus_scheduler #(.READ_PERIOD(100), .GAP_CYCLES(4), .TIMEOUT(64)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .req_esc     (req_esc),
      .fin_esc     (fin_esc),
      .fin_lec     (fin_lec),
      .do_it_esc   (do_it_esc),
      .do_it_lec   (do_it_lec),
      .ack_esc     (ack_esc),
      .dato_listo  (dato_listo),
      .sel_esc     (sel_esc),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, now);
      end
   endtask

   // Advance to 1 time unit after rising edge k, counted from the last reset release.
   task automatic at(input int k);
      while (now < k) begin
         @(posedge clk);
         now++;
      end
      #1;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      now = 0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_do_it_lec", do_it_lec, 1'b0);
      chk("rst_do_it_esc", do_it_esc, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_sel_esc", sel_esc, 1'b0);
      chk("rst_err", err_timeout, 1'b0);
      enable = 1'b1;
      release_reset();
      // periodic reads
      at(100); chk("rd1_not_yet", do_it_lec, 1'b0);
      at(101); chk("rd1_do_it_lec", do_it_lec, 1'b1); chk("rd1_busy", busy, 1'b1); chk("rd1_sel", sel_esc, 1'b0);
      at(111); fin_lec = 1'b1;
      at(112); fin_lec = 1'b0;
      chk("rd1_drop", do_it_lec, 1'b0); chk("rd1_dato", dato_listo, 1'b1); chk("rd1_busy_gap", busy, 1'b1);
      at(113); chk("rd1_dato_pulse", dato_listo, 1'b0);
      at(115); chk("rd1_busy_last_gap", busy, 1'b1);
      at(116); chk("rd1_idle", busy, 1'b0);
      at(200); chk("rd2_not_yet", do_it_lec, 1'b0);
      at(201); chk("rd2_do_it_lec", do_it_lec, 1'b1);
      at(211); fin_lec = 1'b1;
      at(212); fin_lec = 1'b0; chk("rd2_dato", dato_listo, 1'b1); chk("rd2_sel", sel_esc, 1'b0);
      // single write, with a stray fin_lec ignored
      at(220); req_esc = 1'b1; chk("wr1_before", do_it_esc, 1'b0);
      at(221); chk("wr1_do_it_esc", do_it_esc, 1'b1); chk("wr1_sel", sel_esc, 1'b1); chk("wr1_busy", busy, 1'b1);
      at(230); fin_lec = 1'b1;
      at(231); fin_lec = 1'b0; chk("wr1_ign_fin_lec", do_it_esc, 1'b1); chk("wr1_no_dato", dato_listo, 1'b0);
      at(240); fin_esc = 1'b1;
      at(241); fin_esc = 1'b0; req_esc = 1'b0;
      chk("wr1_drop", do_it_esc, 1'b0); chk("wr1_ack", ack_esc, 1'b1);
      at(242); chk("wr1_ack_pulse", ack_esc, 1'b0);
      at(244); chk("wr1_busy_gap", busy, 1'b1);
      at(245); chk("wr1_idle", busy, 1'b0);
      at(250); chk("wr1_sel_hold", sel_esc, 1'b1);
      // write held across a tick: read is served before the next write
      at(290); req_esc = 1'b1;
      at(291); chk("alt_wr_a", do_it_esc, 1'b1);
      at(305); fin_esc = 1'b1;
      at(306); fin_esc = 1'b0; chk("alt_ack_a", ack_esc, 1'b1);
      at(311); chk("alt_lec", do_it_lec, 1'b1); chk("alt_no_esc", do_it_esc, 1'b0); chk("alt_sel_lec", sel_esc, 1'b0);
      at(315); fin_lec = 1'b1;
      at(316); fin_lec = 1'b0; chk("alt_dato", dato_listo, 1'b1);
      at(321); chk("alt_wr_b", do_it_esc, 1'b1); chk("alt_sel_esc", sel_esc, 1'b1);
      at(325); fin_esc = 1'b1;
      at(326); fin_esc = 1'b0; req_esc = 1'b0; chk("alt_ack_b", ack_esc, 1'b1);
      // request withdrawn after grant
      at(340); req_esc = 1'b1;
      at(341); chk("wd_grant", do_it_esc, 1'b1);
      at(346); req_esc = 1'b0;
      at(355); chk("wd_hold", do_it_esc, 1'b1);
      at(361); fin_esc = 1'b1;
      at(362); fin_esc = 1'b0; chk("wd_drop", do_it_esc, 1'b0); chk("wd_ack", ack_esc, 1'b1);
      at(401); chk("rd4_do_it_lec", do_it_lec, 1'b1);
      at(405); fin_lec = 1'b1;
      at(406); fin_lec = 1'b0; chk("rd4_dato", dato_listo, 1'b1);
      // asynchronous reset in ESC
      at(420); req_esc = 1'b1;
      at(425); chk("rst_esc_active", do_it_esc, 1'b1);
      reset = 1'b1; req_esc = 1'b0;
      #1;
      chk("arst_do_it_esc", do_it_esc, 1'b0); chk("arst_sel", sel_esc, 1'b0); chk("arst_busy", busy, 1'b0);
      release_reset();
      at(100); chk("arst_rd_not_yet", do_it_lec, 1'b0);
      at(101); chk("arst_rd", do_it_lec, 1'b1);
      at(105); fin_lec = 1'b1;
      at(106); fin_lec = 1'b0; chk("arst_dato", dato_listo, 1'b1);
      // enable low freezes the tick counter at 20
      at(120); enable = 1'b0;
      at(300); chk("dis_no_read", do_it_lec, 1'b0); chk("dis_idle", busy, 1'b0);
      enable = 1'b1;
      at(380); chk("en_not_yet", do_it_lec, 1'b0);
      at(381); chk("en_read", do_it_lec, 1'b1);
      at(385); fin_lec = 1'b1;
      at(386); fin_lec = 1'b0; chk("en_dato", dato_listo, 1'b1);
`ifdef RTC_SCHED_WDOG_EN
      at(481); chk("to_start", do_it_lec, 1'b1);
      at(544); chk("to_last_cycle", do_it_lec, 1'b1); chk("to_no_err_yet", err_timeout, 1'b0);
      at(545); chk("to_drop", do_it_lec, 1'b0); chk("to_no_dato", dato_listo, 1'b0);
      chk("to_err", err_timeout, 1'b1); chk("to_busy_gap", busy, 1'b1);
      at(581); chk("to_next_read", do_it_lec, 1'b1); chk("to_err_sticky", err_timeout, 1'b1);
      at(585); fin_lec = 1'b1;
      at(586); fin_lec = 1'b0; chk("to_next_dato", dato_listo, 1'b1);
`else
      at(481); chk("nowd_read", do_it_lec, 1'b1);
      at(700); chk("nowd_hold", do_it_lec, 1'b1); chk("nowd_err", err_timeout, 1'b0);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
